// File: rtl/sum3_pkg.sv
// Shared types for the sum-every-3 / split-every-3 datapath pair.
// Checkers on the sum side reuse the same state encoding.
package sum3_pkg;

   localparam int unsigned IW    = 12;
   localparam int unsigned OW    = IW;
   localparam int unsigned BEATS = 3;

   typedef logic [IW-1:0] word_t;
   typedef logic [OW-1:0] beat_t;

   typedef enum logic [1:0] {
      IDLE,
      B0,
      B1,
      B2
   } state_t;

endpackage

// File: rtl/split_every3_if.sv
// Stream bundle between a word source and split_every3: valid-only input, beat output.
interface split_every3_if #(
   parameter int unsigned IW = sum3_pkg::IW
);

   logic          i_dval;
   logic [IW-1:0] i;
   logic          o_dval;
   logic [IW-1:0] o;
   logic          o_ovf;
   logic          o_busy;

   modport master (
      output i_dval,
      output i,
      input  o_dval,
      input  o,
      input  o_ovf,
      input  o_busy
   );

   modport slave (
      input  i_dval,
      input  i,
      output o_dval,
      output o,
      output o_ovf,
      output o_busy
   );

endinterface

// File: rtl/sfifo.sv
// Small synchronous FIFO; pointers carry an extra wrap bit to tell full from empty.
module sfifo #(
   parameter int unsigned W     = 12,
   parameter int unsigned DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic [W-1:0] wdata_i,
   input  logic         pop_i,
   output logic [W-1:0] rdata_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] PtrOne = (AW + 1)'(1);

   logic [AW:0]  wptr_q;
   logic [AW:0]  rptr_q;
   logic [W-1:0] mem_q [DEPTH];

   assign empty_o = (wptr_q == rptr_q);
   assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign rdata_o = mem_q[rptr_q[AW-1:0]];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (push_i) begin
            wptr_q <= wptr_q + PtrOne;
         end
         if (pop_i) begin
            rptr_q <= rptr_q + PtrOne;
         end
      end
   end

   // Storage needs no reset; the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (push_i) begin
         mem_q[wptr_q[AW-1:0]] <= wdata_i;
      end
   end

endmodule

// File: rtl/split_every3.sv
// Splits each accepted word s into three beats q+(r>0), q+(r>1), q that sum back to s.
// A FIFO absorbs input bursts; words arriving while it is full are dropped and flagged.
module split_every3 #(
   parameter int unsigned IW    = sum3_pkg::IW,
   parameter int unsigned DEPTH = 4
) (
   input logic           clk,
   input logic           rst,
   split_every3_if.slave bus
);

   import sum3_pkg::*;

   localparam int unsigned OW = IW;

   logic [IW-1:0] head;
   logic          fifo_full;
   logic          fifo_empty;
   logic          push;
   logic          pop;
   logic [IW-1:0] head_div;
   logic [1:0]    head_rem;

   state_t        state_q, state_d;
   logic [OW-1:0] q_q, q_d;
   logic [1:0]    r_q, r_d;
   logic [OW-1:0] o_q, o_d;
   logic          dval_q, dval_d;
   logic          ovf_q, ovf_d;
   logic          busy_q, busy_d;

   sfifo #(
      .W     (IW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .wdata_i (bus.i),
      .pop_i   (pop),
      .rdata_o (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign head_div = head / IW'(3);
   assign head_rem = 2'(head - head_div * IW'(3));

   // A pop on the same edge frees the slot, so a full FIFO still accepts then.
   assign push  = bus.i_dval & (~fifo_full | pop);
   assign ovf_d = ovf_q | (bus.i_dval & ~push);

   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      r_d     = r_q;
      o_d     = o_q;
      dval_d  = 1'b0;
      pop     = 1'b0;
      unique case (state_q)
         IDLE, B0: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               q_d     = OW'(head_div);
               r_d     = head_rem;
               o_d     = OW'(head_div) + OW'(head_rem != 2'd0);
               dval_d  = 1'b1;
               state_d = B1;
            end else begin
               state_d = IDLE;
            end
         end
         B1: begin
            o_d     = q_q + OW'(r_q > 2'd1);
            dval_d  = 1'b1;
            state_d = B2;
         end
         B2: begin
            o_d     = q_q;
            dval_d  = 1'b1;
            state_d = fifo_empty ? IDLE : B0;
         end
         default: state_d = IDLE;
      endcase
   end

   // Any pop moves to B1, so FIFO occupancy after the edge only matters when not popping.
   assign busy_d = (state_d != IDLE) | ~fifo_empty | push;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         q_q     <= '0;
         r_q     <= '0;
         o_q     <= '0;
         dval_q  <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         r_q     <= r_d;
         o_q     <= o_d;
         dval_q  <= dval_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.o_dval = dval_q;
   assign bus.o      = o_q;
   assign bus.o_ovf  = ovf_q;
   assign bus.o_busy = busy_q;

endmodule
